// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a small circular instruction buffer.
//
// Issues word-aligned fetches to an instruction memory that always accepts and
// answers exactly one cycle later. Responses are written, together with their
// fetch pc, into a DEPTH-entry buffer. The buffer head is presented to decode.
// A redirect flushes the buffer, drops any in-flight response and restarts
// fetching at the redirect target.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     instruction-buffer entries (3..8)
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   imem_req        fetch request this cycle
//   imem_addr       fetch address (always the current fetch pc)
//   imem_rdata      instruction returned one cycle after imem_req
//   redirect_valid  branch/jump redirect from downstream (highest priority)
//   redirect_pc     redirect target, low two bits ignored
//   if_valid        buffer head holds an instruction for decode
//   if_instr        head instruction
//   if_pc           head instruction address
//   id_ready        decode accepts the head when if_valid && id_ready
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_W  = PW'(DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_W) return '0;
    return p + PW'(1);
  endfunction

  logic [31:0]   fetch_pc;
  logic [31:0]   redirect_target;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          inflight_p1;
  logic [31:0]   tag_pc_p1;
  logic [31:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_instr [DEPTH];

  logic          room;
  logic          issue;
  logic          push;
  logic          pop;
  logic          head_ok;

  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Outstanding slots include the response that will land next cycle, so the
  // buffer can never overflow when that response arrives.
  assign room    = ({1'b0, count} + {{CW{1'b0}}, inflight_p1}) < DEPTH_W;
  assign issue   = rst_n && !redirect_valid && room;
  assign push    = inflight_p1 && !redirect_valid;
  assign head_ok = (count != '0);
  assign pop     = if_valid && id_ready;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign if_valid  = head_ok && !redirect_valid;
  // Head is read only from registered storage; zero when the buffer is empty
  // (which includes the whole reset interval, since count resets to zero).
  assign if_instr  = head_ok ? buf_instr[rd_ptr] : '0;
  assign if_pc     = head_ok ? buf_pc[rd_ptr]    : '0;

  // Stage p0 -> p1: fetch pc, request tracking and buffer bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight_p1 <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_target;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight_p1 <= 1'b0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      inflight_p1 <= issue;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p1: capture issued pc, then write the returning response at the tail
  always_ff @(posedge clk) begin
    if (issue) tag_pc_p1 <= fetch_pc;
    if (push) begin
      buf_pc[wr_ptr]    <= tag_pc_p1;
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 3;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: answers one cycle after a request, junk otherwise.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= instr_of(imem_addr);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Directed vector table
  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    tbl.push_back(v);
  endfunction

  // Reference model: queue of buffered pcs plus one pending response.
  logic [31:0] mq[$];
  bit          m_inf;
  logic [31:0] m_pend;
  logic [31:0] m_fpc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          e_req, e_valid;
    logic [31:0] rpc;
    bit          rv, rdy;

    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Release from reset: id_ready low, fill, drain, redirects, pc wrap.
    add(0,0,0, 1,32'h0,   0,0);
    add(0,0,0, 1,32'h4,   0,0);
    add(0,0,0, 1,32'h8,   1,32'h0);
    add(0,0,0, 0,32'hC,   1,32'h0);
    for (int i = 0; i < 6; i++) add(0,0,0, 0,32'hC, 1,32'h0);
    add(1,0,0, 0,32'hC,   1,32'h0);
    add(1,0,0, 1,32'hC,   1,32'h4);
    add(1,0,0, 1,32'h10,  1,32'h8);
    add(0,0,0, 1,32'h14,  1,32'hC);
    add(0,0,0, 0,32'h18,  1,32'hC);
    add(0,0,0, 0,32'h18,  1,32'hC);
    add(0,1,32'h100, 0,32'h18, 0,0);
    add(1,0,0, 1,32'h100, 0,0);
    add(1,0,0, 1,32'h104, 0,0);
    add(1,0,0, 1,32'h108, 1,32'h100);
    add(1,0,0, 1,32'h10C, 1,32'h104);
    add(1,1,32'h203, 0,32'h110, 0,0);
    add(1,0,0, 1,32'h200, 0,0);
    add(1,0,0, 1,32'h204, 0,0);
    add(1,0,0, 1,32'h208, 1,32'h200);
    add(1,1,32'h40, 0,32'h20C, 0,0);
    add(1,1,32'h80, 0,32'h40,  0,0);
    add(1,0,0, 1,32'h80,  0,0);
    add(1,0,0, 1,32'h84,  0,0);
    add(1,0,0, 1,32'h88,  1,32'h80);
    add(1,0,0, 1,32'h8C,  1,32'h84);
    add(1,1,32'hFFFF_FFF8, 0,32'h90, 0,0);
    add(1,0,0, 1,32'hFFFF_FFF8, 0,0);
    add(1,0,0, 1,32'hFFFF_FFFC, 0,0);
    add(1,0,0, 1,32'h0,   1,32'hFFFF_FFF8);
    add(1,0,0, 1,32'h4,   1,32'hFFFF_FFFC);
    add(1,0,0, 1,32'h8,   1,32'h0);
    add(1,0,0, 1,32'hC,   1,32'h4);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req",  {31'b0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_if_valid",  {31'b0, if_valid}, 32'h0);
    chk("rst_if_pc",     if_pc, 32'h0);
    chk("rst_if_instr",  if_instr, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      id_ready = tbl[i].rdy; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("vec%0d_addr", i),  imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i),    if_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_instr", i), if_instr, instr_of(tbl[i].e_pc));
      end
      @(posedge clk);
      #1;
    end

    // Short reset pulse mid-stream, between edges, with a fetch in flight.
    id_ready = 1'b1; redirect_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("pulse_imem_req",  {31'b0, imem_req}, 32'h0);
    chk("pulse_imem_addr", imem_addr, RESET_PC);
    chk("pulse_if_valid",  {31'b0, if_valid}, 32'h0);
    chk("pulse_if_pc",     if_pc, 32'h0);
    chk("pulse_if_instr",  if_instr, 32'h0);
    #1;
    rst_n = 1'b1;

    // Randomized run against the model, starting from the reset state.
    mq.delete(); m_inf = 0; m_pend = '0; m_fpc = RESET_PC;
    for (int i = 0; i < 2000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = (i >= 4) && ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = $urandom;
      endcase
      id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;

      e_req   = !rv && ((mq.size() + int'(m_inf)) < DEPTH);
      e_valid = (mq.size() != 0) && !rv;

      @(negedge clk);
      chk("rnd_req",   {31'b0, imem_req}, {31'b0, e_req});
      chk("rnd_addr",  imem_addr, m_fpc);
      chk("rnd_valid", {31'b0, if_valid}, {31'b0, e_valid});
      if (e_valid) begin
        chk("rnd_pc",    if_pc, mq[0]);
        chk("rnd_instr", if_instr, instr_of(mq[0]));
      end

      if (rv) begin
        mq.delete();
        m_inf = 0;
        m_fpc = {rpc[31:2], 2'b00};
      end else begin
        if (e_valid && rdy) void'(mq.pop_front());
        if (m_inf) mq.push_back(m_pend);
        if (e_req) begin
          m_pend = m_fpc;
          m_fpc  = m_fpc + 32'd4;
        end
        m_inf = e_req;
      end

      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
